fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer that owns the program counter and drives the instruction memory's address port. It tracks the memory's one-cycle synchronous read latency and presents fetched instructions to decode through a valid/ready handshake. A one-entry skid buffer keeps throughput at one instruction per cycle and creates no combinational path from `in_ready` to the memory address. It sits between the instruction memory and the decode stage, and takes control-flow redirects from the branch-resolution logic.

## Interface
- `PC_W`, 32, program-counter and memory-address width.
- `INST_W`, 32, instruction width.
- `RESET_PC`, 0, first fetch address after reset.
- `PC_STEP`, 1, increment per fetch. Memory is word-indexed, so the PC is a word index.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `out_imem_pc`  out  PC_W  address to the instruction memory. Driven straight from the `pc_q` register.
- `in_imem_inst`  in  INST_W  instruction memory read data. It is valid one cycle after the address is presented.
- `in_redirect`  in  1  branch/jump redirect strobe.
- `in_redirect_pc`  in  PC_W  redirect target.
- `in_ready`  in  1  decode accepts the current output.
- `out_valid`  out  1  `out_inst`/`out_pc` hold a live instruction.
- `out_inst`  out  INST_W  instruction to decode.
- `out_pc`  out  PC_W  address of `out_inst`.
- `out_halted`  out  1  fetch stopped on the halt instruction. Tied 0 without `IFETCH_HALT_EN`.

## Operation
- Registers:
  - `pc_q`: next address to issue.
  - `issue_q`, `rsp_pc_q`: the memory output this cycle answers an issue made last cycle, at address `rsp_pc_q`.
  - `skid_v_q`, `skid_inst_q`, `skid_pc_q`: held instruction.
  - `halted_q`: fetch stopped on halt.
- Output mux:
  - `out_valid = skid_v_q | issue_q`.
  - When `skid_v_q` is set, `out_inst`/`out_pc` come from the skid registers; otherwise they come from `in_imem_inst`/`rsp_pc_q`.
- Issue:
  - `issue_en = (in_ready | ~out_valid) & ~halted_q`.
  - On issue: `issue_q<=1`, `rsp_pc_q<=pc_q`, `pc_q<=pc_q+PC_STEP`, which wraps modulo 2^PC_W.
  - With no issue, `issue_q<=0`. The memory still reads `pc_q`, but that response is ignored.
- Skid capture: if `issue_q & ~skid_v_q & ~in_ready`, capture the memory output and `rsp_pc_q` into the skid registers. The skid empties when `skid_v_q & in_ready`.
- Output-source states, decoded from the registers:
  - EMPTY: `issue_q=0`, `skid_v_q=0`.
  - LIVE: `issue_q=1`, `skid_v_q=0`. LIVE with `~in_ready` goes to HELD.
  - HELD: `skid_v_q=1`. HELD with `in_ready` goes to LIVE on the next cycle.
  - HALTED: `halted_q=1`.
- Redirect, which beats stall and issue:
  - `pc_q<=in_redirect_pc`.
  - Squash: `issue_q<=0`, `skid_v_q<=0`, `halted_q<=0`.
  - The current-cycle output and handshake are unaffected; an accept in that same cycle stands.
- Priority: `rst` > `in_redirect` > halt > normal issue/stall.

## Timing
- Reset values: `pc_q=RESET_PC`, `issue_q=0`, `skid_v_q=0`, `halted_q=0`.
  - Hence `out_valid=0`, `out_halted=0` and `out_imem_pc=RESET_PC`.
  - The skid and `rsp_pc` data registers reset to 0.
- First fetch: the first cycle with `rst` low issues `RESET_PC`. The next cycle has `out_valid=1`, `out_pc=RESET_PC`.
- Steady state: one instruction per cycle while `in_ready=1`, with no bubble on stall release.
- Stall: `out_inst`/`out_pc` stay stable while `out_valid & ~in_ready`, in both LIVE and HELD.
- Redirect latency: strobe in cycle N, `out_valid=0` in N+1, target instruction valid in N+2.
- Reset mid-stream: everything in flight and in the skid is discarded. Behaviour matches the post-reset sequence.
- PC wrap: `2^PC_W-1` is followed by 0, with no special handling.

## Configuration
- `IFETCH_HALT_EN` defined:
  - An accepted instruction (`out_valid & in_ready`) equal to `HALT_INST` sets `halted_q`, squashes `issue_q` and the skid, and blocks issue.
  - `out_halted=1` from the next cycle. Only a redirect or `rst` clears it.
- Not defined: `halted_q` is constant 0, `out_halted` is tied 0, and `HALT_INST` is fetched like any other instruction.

## Structure
- Package `ifetch_pkg` holds:
  - `PC_W`/`INST_W` defaults.
  - `HALT_INST = 32'h0000_0000`, which matches the memory's zero fill.
  - A `pc_t` typedef.
  - The output-source state enum (EMPTY/LIVE/HELD/HALTED), used for assertions and debug.
- Sub-module `ifetch_skid`: a one-entry holding register with capture/drain controls, carrying instruction plus PC.

## Test plan
- Reset release, `in_ready=1`: `out_pc` sequence 0,1,2,3 on consecutive cycles starting one cycle after `rst` falls; `out_imem_pc` leads `out_pc` by one.
- `in_ready` low for 3 cycles while `out_pc=5`:
  - `out_pc=5` and `out_inst` stay stable throughout.
  - On release, 5 is accepted, then 6 in the next cycle, with no gap and no duplicate.
- Redirect to 0x40 in the same cycle as a stall:
  - The next cycle has `out_valid=0`.
  - The cycle after that has `out_pc=0x40`.
  - Neither the old skid entry nor the old in-flight instruction ever appears.
- `rst` asserted mid-stream with the skid full: the following cycle has `out_valid=0`, then the fetch sequence restarts at `RESET_PC`.
- `IFETCH_HALT_EN`, memory `[3]=0`, all other words nonzero:
  - After `out_pc=3` is accepted, `out_halted=1` and `out_valid=0` persist.
  - A redirect to 0 clears `out_halted` and restarts fetch.
- `pc_q=32'hFFFF_FFFF`: the next issued address is 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch block.
//   DEF_PC_W / DEF_INST_W : default address and instruction widths
//   HALT_INST             : halt opcode (all zeros, matching memory zero fill)
//   pc_t                  : program-counter type at the default width
//   src_state_t           : output-source state, decoded for debug/assertions
package ifetch_pkg;

   localparam int DEF_PC_W   = 32;
   localparam int DEF_INST_W = 32;

   localparam logic [DEF_INST_W-1:0] HALT_INST = 32'h0000_0000;

   typedef logic [DEF_PC_W-1:0] pc_t;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LIVE   = 2'd1,
      ST_HELD   = 2'd2,
      ST_HALTED = 2'd3
   } src_state_t;

endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry holding register for an instruction and its PC.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_flush             : discard the held entry (wins over capture)
//   i_capture           : load i_inst/i_pc and mark the entry valid
//   i_drain             : entry consumed downstream, mark it empty
//   i_inst, i_pc        : data to capture
//   o_valid, o_inst, o_pc : held entry
module ifetch_skid #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_capture,
   input  logic              i_drain,
   input  logic [INST_W-1:0] i_inst,
   input  logic [PC_W-1:0]   i_pc,
   output logic              o_valid,
   output logic [INST_W-1:0] o_inst,
   output logic [PC_W-1:0]   o_pc
);

   logic              r_valid;
   logic [INST_W-1:0] r_inst;
   logic [PC_W-1:0]   r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_inst  <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_capture) begin
         r_valid <= 1'b1;
         r_inst  <= i_inst;
         r_pc    <= i_pc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_inst  = r_inst;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer. Owns the PC, drives the
// instruction-memory address, tracks the one-cycle memory read latency and
// hands instructions to decode over valid/ready, with a one-entry skid so
// in_ready never reaches the memory address combinationally.
// Optional feature macro: IFETCH_HALT_EN (stop fetching on HALT_INST).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   out_imem_pc     : memory address (straight from the PC register)
//   in_imem_inst    : memory read data, valid one cycle after the address
//   in_redirect     : redirect strobe; in_redirect_pc is the new target
//   in_ready        : decode accepts the current output
//   out_valid/out_inst/out_pc : instruction to decode and its address
//   out_halted      : fetch stopped on halt (0 without IFETCH_HALT_EN)
//   out_dbg_state   : decoded output-source state
// Handshake: a transfer happens in any cycle where out_valid & in_ready;
// while out_valid & ~in_ready, out_inst/out_pc hold steady.
module fetch_controller
   import ifetch_pkg::*;
#(
   parameter int            PC_W     = DEF_PC_W,
   parameter int            INST_W   = DEF_INST_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int            PC_STEP  = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   out_imem_pc,
   input  logic [INST_W-1:0] in_imem_inst,
   input  logic              in_redirect,
   input  logic [PC_W-1:0]   in_redirect_pc,
   input  logic              in_ready,
   output logic              out_valid,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_halted,
   output src_state_t        out_dbg_state
);

   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_rsp_pc;
   logic              r_issue;

   logic              w_skid_v;
   logic [INST_W-1:0] w_skid_inst;
   logic [PC_W-1:0]   w_skid_pc;
   logic              w_out_valid;
   logic [INST_W-1:0] w_out_inst;
   logic              w_accept;
   logic              w_issue_en;
   logic              w_capture;
   logic              w_drain;
   logic              w_flush;
   logic              w_halt_hit;
   logic              w_halted;
   src_state_t        w_state;

   assign w_out_valid = w_skid_v | r_issue;
   assign w_out_inst  = w_skid_v ? w_skid_inst : in_imem_inst;
   assign w_accept    = w_out_valid & in_ready;
   assign w_issue_en  = (in_ready | ~w_out_valid) & ~w_halted;

   // A stalled live response is parked in the skid; the memory output will
   // move on next cycle, so this is the only chance to keep it.
   assign w_capture = r_issue & ~w_skid_v & ~in_ready & ~in_redirect;
   assign w_drain   = w_skid_v & in_ready;
   assign w_flush   = in_redirect | w_halt_hit;

`ifdef IFETCH_HALT_EN
   logic r_halted;

   assign w_halt_hit = w_accept & (w_out_inst == INST_W'(HALT_INST));
   assign w_halted   = r_halted;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_halted <= 1'b0;
      end else if (in_redirect) begin
         r_halted <= 1'b0;
      end else if (w_halt_hit) begin
         r_halted <= 1'b1;
      end
   end
`else
   assign w_halt_hit = 1'b0;
   assign w_halted   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_issue  <= 1'b0;
         r_rsp_pc <= '0;
      end else if (in_redirect) begin
         r_pc    <= in_redirect_pc;
         r_issue <= 1'b0;
      end else if (w_halt_hit) begin
         r_issue <= 1'b0;
      end else if (w_issue_en) begin
         r_issue  <= 1'b1;
         r_rsp_pc <= r_pc;
         r_pc     <= r_pc + PC_W'(PC_STEP);   // wraps modulo 2^PC_W
      end else begin
         // Memory still reads r_pc; that response is simply not marked live.
         r_issue <= 1'b0;
      end
   end

   ifetch_skid #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (w_flush),
      .i_capture (w_capture),
      .i_drain   (w_drain),
      .i_inst    (in_imem_inst),
      .i_pc      (r_rsp_pc),
      .o_valid   (w_skid_v),
      .o_inst    (w_skid_inst),
      .o_pc      (w_skid_pc)
   );

   always_comb begin
      w_state = ST_EMPTY;
      if (w_halted) begin
         w_state = ST_HALTED;
      end else if (w_skid_v) begin
         w_state = ST_HELD;
      end else if (r_issue) begin
         w_state = ST_LIVE;
      end
   end

   assign out_imem_pc   = r_pc;
   assign out_valid     = w_out_valid;
   assign out_inst      = w_out_inst;
   assign out_pc        = w_skid_v ? w_skid_pc : r_rsp_pc;
   assign out_halted    = w_halted;
   assign out_dbg_state = w_state;

   // Halted means nothing in flight and nothing held.
   a_halt_quiet: assert property (@(posedge clk) disable iff (rst)
      w_halted |-> (~r_issue & ~w_skid_v));

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller with a
// word-indexed memory model (word 3 is the zero/halt word) and an
// accept-order scoreboard of expected PCs.
module tb_fetch_controller;
   import ifetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   pc_t         out_imem_pc;
   logic [31:0] imem_q = '0;
   logic        in_redirect = 1'b0;
   pc_t         in_redirect_pc = '0;
   logic        in_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_inst;
   pc_t         out_pc;
   logic        out_halted;
   src_state_t  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_controller dut (
      .clk            (clk),
      .rst            (rst),
      .out_imem_pc    (out_imem_pc),
      .in_imem_inst   (imem_q),
      .in_redirect    (in_redirect),
      .in_redirect_pc (in_redirect_pc),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_halted     (out_halted),
      .out_dbg_state  (dbg_state)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'd3) ? 32'h0 : (a ^ 32'hC0DE_0000);
   endfunction

   // synchronous-read memory: data for an address appears the next cycle
   always @(posedge clk) imem_q <= mem_word(out_imem_pc);

   // scoreboard: every accepted transfer must be the next expected PC
   always @(negedge clk) begin
      if (!rst && out_valid && in_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL accept_unexpected pc=%h required=none", out_pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (out_pc !== e) begin
               errors++; $display("FAIL accept_pc got=%h want=%h", out_pc, e);
            end
            checks++;
            if (out_inst !== mem_word(e)) begin
               errors++; $display("FAIL accept_inst got=%h want=%h", out_inst, mem_word(e));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // leaves the bench at the start of the first cycle with rst low
   task automatic do_reset();
      step(); rst = 1'b1; in_ready = 1'b0; in_redirect = 1'b0;
      step(); step(); rst = 1'b0; in_ready = 1'b1;
      exp_q.delete();
   endtask

   task automatic push_range(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
   endtask

   task automatic end_test(input string name);
      step(); in_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL %s_drain left=%0d want=0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_ready = 1'b0;
      step(); step(); @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      checks++;
      if (out_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", out_halted); end
      checks++;
      if (out_imem_pc !== 32'h0) begin errors++; $display("FAIL reset_imem_pc got=%h want=0", out_imem_pc); end
      checks++;
      if (dbg_state !== ST_EMPTY) begin errors++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_EMPTY); end
   endtask

   task automatic test_first_fetch();
      do_reset(); push_range(0, 8);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL first_c0_valid got=%b want=0", out_valid); end
      checks++;
      if (out_imem_pc !== 32'h0) begin errors++; $display("FAIL first_c0_imem got=%h want=0", out_imem_pc); end
      for (int k = 1; k <= 8; k++) begin
         step(); @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid c=%0d got=%b want=1", k, out_valid); end
         checks++;
         if (out_imem_pc !== 32'(k)) begin errors++; $display("FAIL first_imem_lead got=%h want=%h", out_imem_pc, 32'(k)); end
      end
      end_test("first");
   endtask

   task automatic test_stall();
      do_reset(); push_range(0, 10);
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin step(); @(negedge clk); end
      for (int k = 6; k <= 8; k++) begin
         step(); in_ready = 1'b0; @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'd5) begin
            errors++; $display("FAIL stall_pc c=%0d got=%h/%b want=5/1", k, out_pc, out_valid);
         end
         checks++;
         if (out_inst !== mem_word(5)) begin errors++; $display("FAIL stall_inst got=%h want=%h", out_inst, mem_word(5)); end
      end
      checks++;
      if (dbg_state !== ST_HELD) begin errors++; $display("FAIL stall_state got=%0d want=%0d", dbg_state, ST_HELD); end
      step(); in_ready = 1'b1; @(negedge clk);
      step(); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd6) begin
         errors++; $display("FAIL stall_release got=%h/%b want=6/1", out_pc, out_valid);
      end
      for (int k = 11; k <= 13; k++) begin step(); @(negedge clk); end
      end_test("stall");
   endtask

   task automatic test_redirect();
      do_reset(); push_range(0, 4);
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin step(); @(negedge clk); end
      step(); in_ready = 1'b0; @(negedge clk);
      step(); in_redirect = 1'b1; in_redirect_pc = 32'h40; push_range(32'h40, 4);
      @(negedge clk);
      checks++;
      if (dbg_state !== ST_HELD || out_pc !== 32'd4) begin
         errors++; $display("FAIL redir_held got=%0d/%h want=%0d/4", dbg_state, out_pc, ST_HELD);
      end
      step(); in_redirect = 1'b0; in_ready = 1'b1; @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%b want=0", out_valid); end
      checks++;
      if (out_imem_pc !== 32'h40) begin errors++; $display("FAIL redir_imem got=%h want=40", out_imem_pc); end
      step(); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
         errors++; $display("FAIL redir_target got=%h/%b want=40/1", out_pc, out_valid);
      end
      step(); @(negedge clk);
      step(); @(negedge clk);
      // redirect with an accept in the same cycle: 0x43 must still be taken
      step(); in_redirect = 1'b1; in_redirect_pc = 32'h80; push_range(32'h80, 2);
      @(negedge clk);
      step(); in_redirect = 1'b0; @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL redir2_bubble got=%b want=0", out_valid); end
      step(); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h80) begin
         errors++; $display("FAIL redir2_target got=%h/%b want=80/1", out_pc, out_valid);
      end
      step(); @(negedge clk);
      end_test("redirect");
   endtask

   task automatic test_reset_mid();
      do_reset(); push_range(0, 3);
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin step(); @(negedge clk); end
      step(); in_ready = 1'b0; @(negedge clk);
      step(); rst = 1'b1; @(negedge clk);
      checks++;
      if (dbg_state !== ST_HELD) begin errors++; $display("FAIL rstmid_held got=%0d want=%0d", dbg_state, ST_HELD); end
      step(); rst = 1'b0; in_ready = 1'b1; push_range(0, 4); @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
      checks++;
      if (out_imem_pc !== 32'h0) begin errors++; $display("FAIL rstmid_imem got=%h want=0", out_imem_pc); end
      step(); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
         errors++; $display("FAIL rstmid_restart got=%h/%b want=0/1", out_pc, out_valid);
      end
      for (int k = 0; k < 3; k++) begin step(); @(negedge clk); end
      end_test("rstmid");
   endtask

   task automatic test_wrap();
      do_reset(); in_redirect = 1'b1; in_redirect_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      step(); in_redirect = 1'b0;
      exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF); push_range(0, 2);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_imem_pc !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL wrap_start got=%h/%b want=fffffffe/0", out_imem_pc, out_valid);
      end
      step(); @(negedge clk);
      checks++;
      if (out_imem_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max got=%h want=ffffffff", out_imem_pc); end
      step(); @(negedge clk);
      checks++;
      if (out_imem_pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h want=0", out_imem_pc); end
      step(); @(negedge clk);
      step(); @(negedge clk);
      end_test("wrap");
   endtask

`ifdef IFETCH_HALT_EN
   task automatic test_halt();
      do_reset(); push_range(0, 4);
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin step(); @(negedge clk); end
      for (int k = 5; k <= 8; k++) begin
         step(); if (k == 8) begin in_redirect = 1'b1; in_redirect_pc = 32'h0; end
         @(negedge clk);
         checks++;
         if (out_halted !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL halt_hold c=%0d got=%b/%b want=1/0", k, out_halted, out_valid);
         end
      end
      step(); in_redirect = 1'b0; push_range(0, 2); @(negedge clk);
      checks++;
      if (out_halted !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL halt_clear got=%b/%b want=0/0", out_halted, out_valid);
      end
      step(); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
         errors++; $display("FAIL halt_restart got=%h/%b want=0/1", out_pc, out_valid);
      end
      step(); @(negedge clk);
      end_test("halt");
   endtask
`else
   task automatic test_halt();
      do_reset(); push_range(0, 6);
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         step(); @(negedge clk);
         checks++;
         if (out_halted !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL nohalt_flow c=%0d got=%b/%b want=0/1", k, out_halted, out_valid);
         end
      end
      end_test("nohalt");
   endtask
`endif

   task automatic test_back_to_back();
      logic        held;
      logic [31:0] held_pc;
      logic [31:0] held_inst;
      held = 1'b0; held_pc = '0; held_inst = '0;
      do_reset(); push_range(0, 60);
      @(negedge clk);
      for (int i = 0; i < 60; i++) begin
         step(); in_ready = ($urandom_range(0, 3) != 0); @(negedge clk);
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== held_pc || out_inst !== held_inst) begin
               errors++; $display("FAIL b2b_stable got=%h/%h want=%h/%h", out_pc, out_inst, held_pc, held_inst);
            end
         end
         held = out_valid && !in_ready; held_pc = out_pc; held_inst = out_inst;
      end
      for (int i = 0; i < 100; i++) begin
         step();
         if (exp_q.size() == 0) break;
         in_ready = 1'b1; @(negedge clk);
      end
      in_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain left=%0d want=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_redirect();
      test_reset_mid();
      test_wrap();
      test_halt();
      test_back_to_back();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
